// File: rtl/kpn_pkg.sv
// Shared types and elaboration helpers for the KPN multiply/accumulate process node.
package kpn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0 so a plain-product node adds no guard bits.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int out_w(input int data_w, input int acc_len);
    return 2 * data_w + clog2(acc_len);
  endfunction

endpackage

// File: rtl/kpn_mac_process_if.sv
// Channel bundle for the MAC node: two FWFT input FIFOs, one output FIFO, status.
interface kpn_mac_process_if
  import kpn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
);
  // Inputs: entry_N is valid while empty_N=0 and is consumed by rd_N in that cycle.
  // Output: output_1 is accepted on any cycle with wr=1, and wr only rises while full_o=0.
  logic [DATA_W-1:0] entry_1;
  logic              empty_1;
  logic              rd_1;
  logic [DATA_W-1:0] entry_2;
  logic              empty_2;
  logic              rd_2;
  logic [OUT_W-1:0]  output_1;
  logic              full_o;
  logic              wr;
  logic              busy;
  state_e            dbg_state;

  modport slave (
    input  entry_1, empty_1, entry_2, empty_2, full_o,
    output rd_1, rd_2, output_1, wr, busy, dbg_state
  );

  modport master (
    output entry_1, empty_1, entry_2, empty_2, full_o,
    input  rd_1, rd_2, output_1, wr, busy, dbg_state
  );

endinterface

// File: rtl/kpn_mul_pipe.sv
// Registered multiplier: product captured on valid_i, delivered MUL_LAT cycles later.
module kpn_mul_pipe
  import kpn_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SIGNED  = 0,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  valid_o,
  output logic [2*DATA_W-1:0]   prod_o
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]      a_ext;
  logic [PW-1:0]      b_ext;
  logic [PW-1:0]      prod_raw;
  logic [PW-1:0]      pipe_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;

  // Low PW bits of the extended product are exact for both signednesses.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
      b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    end else begin
      a_ext = {{DATA_W{1'b0}}, a_i};
      b_ext = {{DATA_W{1'b0}}, b_i};
    end
    prod_raw = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) pipe_q[0] <= prod_raw;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[MUL_LAT-1];
  assign prod_o  = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/kpn_mac_process.sv
// KPN process node: pops one token pair, multiplies, accumulates ACC_LEN products, pushes one result.
module kpn_mac_process
  import kpn_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SIGNED  = 0,
  parameter int MUL_LAT = 2,
  parameter int ACC_LEN = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  kpn_mac_process_if.slave io
);

  localparam int OUT_W = out_w(DATA_W, ACC_LEN);
  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = clog2(ACC_LEN) + 1;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pop;
  logic               push;
  logic               mul_vld;
  logic [PW-1:0]      prod;
  logic [OUT_W-1:0]   prod_ext;
  logic [OUT_W-1:0]   acc_sum;

  kpn_mul_pipe #(
    .DATA_W  (DATA_W),
    .SIGNED  (SIGNED),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (clk),
    .rst_n   (reset_n),
    .valid_i (pop),
    .a_i     (io.entry_1),
    .b_i     (io.entry_2),
    .valid_o (mul_vld),
    .prod_o  (prod)
  );

  always_comb begin
    if (SIGNED != 0) prod_ext = OUT_W'($signed(prod));
    else             prod_ext = OUT_W'(prod);
    acc_sum = acc_q + prod_ext;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      // Both channels pop together or not at all; nothing is popped while reset is held.
      IDLE: begin
        if (reset_n && !io.empty_1 && !io.empty_2) begin
          pop     = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        if (mul_vld) begin
          if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
            out_d   = acc_sum;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            acc_d   = acc_sum;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        push = !io.full_o;
        if (push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign io.rd_1      = pop;
  assign io.rd_2      = pop;
  assign io.wr        = push;
  assign io.output_1  = out_q;
  assign io.busy      = (state_q != IDLE) || (cnt_q != '0);
  assign io.dbg_state = state_q;

endmodule

// File: tb/tb_kpn_mac_process.sv
// Bench for kpn_mac_process: three configurations driven side by side, checked against a pair-level model.
module tb_kpn_mac_process;
  import kpn_pkg::*;

  localparam int NK = 3;  // 0: defaults, 1: SIGNED=1, 2: ACC_LEN=4 with MUL_LAT=1

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus / observation vectors ----------------
  logic [NK-1:0][15:0] e1, e2;
  logic [NK-1:0]       emp1, emp2, full;
  logic [NK-1:0]       rd1, rd2, wr, busy;
  logic [NK-1:0][33:0] outv;
  logic [NK-1:0][1:0]  st;

  kpn_mac_process_if #(.DATA_W(16), .OUT_W(32)) if_a ();
  kpn_mac_process_if #(.DATA_W(16), .OUT_W(32)) if_s ();
  kpn_mac_process_if #(.DATA_W(16), .OUT_W(34)) if_c ();

  assign if_a.entry_1 = e1[0];  assign if_a.entry_2 = e2[0];
  assign if_a.empty_1 = emp1[0]; assign if_a.empty_2 = emp2[0]; assign if_a.full_o = full[0];
  assign if_s.entry_1 = e1[1];  assign if_s.entry_2 = e2[1];
  assign if_s.empty_1 = emp1[1]; assign if_s.empty_2 = emp2[1]; assign if_s.full_o = full[1];
  assign if_c.entry_1 = e1[2];  assign if_c.entry_2 = e2[2];
  assign if_c.empty_1 = emp1[2]; assign if_c.empty_2 = emp2[2]; assign if_c.full_o = full[2];

  assign rd1[0] = if_a.rd_1; assign rd2[0] = if_a.rd_2; assign wr[0] = if_a.wr; assign busy[0] = if_a.busy;
  assign rd1[1] = if_s.rd_1; assign rd2[1] = if_s.rd_2; assign wr[1] = if_s.wr; assign busy[1] = if_s.busy;
  assign rd1[2] = if_c.rd_1; assign rd2[2] = if_c.rd_2; assign wr[2] = if_c.wr; assign busy[2] = if_c.busy;
  assign outv[0] = 34'(if_a.output_1);
  assign outv[1] = 34'(if_s.output_1);
  assign outv[2] = if_c.output_1;
  assign st[0] = if_a.dbg_state;
  assign st[1] = if_s.dbg_state;
  assign st[2] = if_c.dbg_state;

  kpn_mac_process #(.DATA_W(16), .SIGNED(0), .MUL_LAT(2), .ACC_LEN(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .io(if_a));
  kpn_mac_process #(.DATA_W(16), .SIGNED(1), .MUL_LAT(2), .ACC_LEN(1)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .io(if_s));
  kpn_mac_process #(.DATA_W(16), .SIGNED(0), .MUL_LAT(1), .ACC_LEN(4)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .io(if_c));

  function automatic int acc_len_of(int k); return (k == 2) ? 4 : 1; endfunction
  function automatic bit signed_of(int k);  return (k == 1);         endfunction
  function automatic int ow_of(int k);      return (k == 2) ? 34 : 32; endfunction

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: pairs in, result tokens out ----------------
  longint      m_sum [NK];
  int          m_cnt [NK];
  int          rd_cyc[NK];
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [33:0] exp_q2[$];

  function automatic longint ext(int k, logic [15:0] v);
    if (signed_of(k)) return longint'($signed(v));
    return longint'(v);
  endfunction

  function automatic logic [33:0] trunc(int k, longint v);
    logic [63:0] m;
    m = (64'd1 << ow_of(k)) - 64'd1;
    return 34'(v & m);
  endfunction

  function automatic int exp_size(int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic exp_push(int k, logic [33:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic exp_pop(int k, output logic [33:0] v);
    case (k)
      0:       v = exp_q0.pop_front();
      1:       v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  always @(negedge clk) begin
    logic [33:0] ev;
    if (!reset_n) begin
      for (int k = 0; k < NK; k++) begin m_sum[k] = 0; m_cnt[k] = 0; end
      exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (rd1[k] || rd2[k]) begin
          check_val($sformatf("rd_1_%0d", k), rd1[k], 1);
          check_val($sformatf("rd_2_%0d", k), rd2[k], 1);
          check_val($sformatf("pop_nonempty_%0d", k), emp1[k] | emp2[k], 0);
          rd_cyc[k] = cyc;
          m_sum[k] = m_sum[k] + ext(k, e1[k]) * ext(k, e2[k]);
          m_cnt[k]++;
          if (m_cnt[k] == acc_len_of(k)) begin
            exp_push(k, trunc(k, m_sum[k]));
            m_sum[k] = 0;
            m_cnt[k] = 0;
          end
        end
        if (wr[k]) begin
          check_val($sformatf("wr_expected_%0d", k), exp_size(k) > 0, 1);
          if (exp_size(k) > 0) begin
            exp_pop(k, ev);
            check_val($sformatf("wr_data_%0d", k), outv[k], ev);
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic wait_pop(int k);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (rd1[k]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_val($sformatf("pop_seen_%0d", k), got, 1);
    @(posedge clk); #1;
    emp1[k] = 1'b1;
    emp2[k] = 1'b1;
  endtask

  task automatic push_pair(int k, logic [15:0] a, logic [15:0] b);
    e1[k] = a; e2[k] = b;
    emp1[k] = 1'b0; emp2[k] = 1'b0;
    wait_pop(k);
  endtask

  task automatic wait_wr(int k, bit rnd_full, output int lat, output logic [33:0] v);
    bit got;
    got = 1'b0; lat = -1; v = '0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (wr[k]) begin
        got = 1'b1; lat = cyc - rd_cyc[k]; v = outv[k];
      end else begin
        @(posedge clk); #1;
        if (rnd_full) full[k] = ($urandom_range(0, 2) == 0);
      end
    end
    check_val($sformatf("wr_seen_%0d", k), got, 1);
    @(posedge clk); #1;
    full[k] = 1'b0;
  endtask

  task automatic check_reset(string tag);
    for (int k = 0; k < NK; k++) begin
      check_val($sformatf("%s_rd_%0d", tag, k), {rd1[k], rd2[k]}, 0);
      check_val($sformatf("%s_wr_%0d", tag, k), wr[k], 0);
      check_val($sformatf("%s_out_%0d", tag, k), outv[k], 0);
      check_val($sformatf("%s_busy_%0d", tag, k), busy[k], 0);
      check_val($sformatf("%s_state_%0d", tag, k), st[k], 2'(IDLE));
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'(($urandom_range(0, 15)));
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int          lat;
    logic [33:0] v;
    logic [15:0] pa[4];
    logic [15:0] pb[4];
    logic [15:0] ra, rb;

    e1 = '0; e2 = '0; emp1 = '1; emp2 = '1; full = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Plain product, latency and busy on the default node
    push_pair(0, 16'h0010, 16'h0032);
    @(negedge clk);
    check_val("a_busy_mul", busy[0], 1);
    @(posedge clk); #1;
    wait_wr(0, 0, lat, v);
    check_val("a_lat", lat, 3);
    check_val("a_out", v, 34'h0_0000_0320);
    push_pair(0, 16'hFFFF, 16'hFFFF);
    wait_wr(0, 0, lat, v);
    check_val("a_out_max", v, 34'h0_FFFE_0001);

    // Signed operands
    push_pair(1, 16'hFFFE, 16'h0003);
    wait_wr(1, 0, lat, v);
    check_val("s_neg", v, 34'h0_FFFF_FFFA);
    push_pair(1, 16'h8000, 16'h8000);
    wait_wr(1, 0, lat, v);
    check_val("s_minmin", v, 34'h0_4000_0000);

    // Exactly one channel empty: no pop
    e1[0] = 16'h0020; emp1[0] = 1'b0; emp2[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_val("a_one_empty_rd", {rd1[0], rd2[0]}, 0);
      @(posedge clk); #1;
    end
    e2[0] = 16'h0020; emp2[0] = 1'b0;
    wait_pop(0);
    wait_wr(0, 0, lat, v);
    check_val("a_after_empty", v, 34'h0_0000_0400);

    e2[1] = 16'h0007; emp2[1] = 1'b0; emp1[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("s_one_empty_rd", {rd1[1], rd2[1]}, 0);
      @(posedge clk); #1;
    end
    e1[1] = 16'hFFFF; emp1[1] = 1'b0;
    wait_pop(1);
    wait_wr(1, 0, lat, v);
    check_val("s_after_empty", v, 34'h0_FFFF_FFF9);

    // Backpressure: full from WRITE entry for 5 cycles, next pair already waiting
    push_pair(0, 16'h0007, 16'h0009);
    full[0] = 1'b1;
    e1[0] = 16'h0011; e2[0] = 16'h0013; emp1[0] = 1'b0; emp2[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("a_mul_no_rd", rd1[0] | rd2[0], 0);
      @(posedge clk); #1;
    end
    repeat (5) begin
      @(negedge clk);
      check_val("a_stall_wr", wr[0], 0);
      check_val("a_stall_rd", rd1[0] | rd2[0], 0);
      check_val("a_stall_out", outv[0], 34'h0_0000_003F);
      @(posedge clk); #1;
    end
    full[0] = 1'b0;
    @(negedge clk);
    check_val("a_unstall_wr", wr[0], 1);
    check_val("a_unstall_out", outv[0], 34'h0_0000_003F);
    @(posedge clk); #1;
    wait_pop(0);
    wait_wr(0, 0, lat, v);
    check_val("a_after_stall", v, 34'h0_0000_0143);

    // full rises on the very cycle WRITE is entered
    push_pair(1, 16'h0005, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    full[1] = 1'b1;
    @(negedge clk);
    check_val("s_late_full_wr", wr[1], 0);
    @(posedge clk); #1;
    full[1] = 1'b0;
    @(negedge clk);
    check_val("s_late_full_release", wr[1], 1);
    check_val("s_late_full_out", outv[1], 34'h0_FFFF_FFFB);
    @(posedge clk); #1;

    // Accumulation of four products
    pa = '{16'd1, 16'd3, 16'd5, 16'd7};
    pb = '{16'd2, 16'd4, 16'd6, 16'd8};
    for (int i = 0; i < 4; i++) begin
      push_pair(2, pa[i], pb[i]);
      if (i < 3) begin
        repeat (3) begin
          @(negedge clk);
          check_val("c_no_early_wr", wr[2], 0);
          check_val("c_busy_partial", busy[2], 1);
          @(posedge clk); #1;
        end
      end
    end
    wait_wr(2, 0, lat, v);
    check_val("c_lat", lat, 2);
    check_val("c_sum", v, 34'd100);
    @(negedge clk);
    check_val("c_idle_busy", busy[2], 0);
    @(posedge clk); #1;

    // Asynchronous reset in MUL after two of four pairs
    push_pair(2, 16'd2, 16'd3);
    push_pair(2, 16'd4, 16'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_pair(2, 16'd1, 16'd1);
    wait_wr(2, 0, lat, v);
    check_val("c_after_rst", v, 34'd4);

    // Randomized traffic with random gaps, one-sided availability and backpressure
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 24; i++) begin
        ra = pick_operand();
        rb = pick_operand();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if ($urandom_range(0, 3) == 0) begin
          e1[k] = ra; emp1[k] = 1'b0;
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        push_pair(k, ra, rb);
        if (((i + 1) % acc_len_of(k)) == 0) wait_wr(k, 1, lat, v);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) begin
      check_val($sformatf("drain_%0d", k), exp_size(k), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kpn_mac_process.md
Name: kpn_mac_process

Overview:
- Parametrised next-generation multiplier process node for the KPN fabric.
- Consumes one token from each of two input channels (FWFT FIFOs) and multiplies the pair.
- Optionally accumulates ACC_LEN consecutive products, then writes one result token to an output FIFO.
- Replaces the fixed 16x16 node and adds full empty/full handshakes, signed mode, configurable multiplier latency and accumulation.

Parameters:
- DATA_W, 16: width of each input token.
- SIGNED, 0: 0 = unsigned operands, 1 = two's-complement operands.
- MUL_LAT, 2: multiplier pipeline depth in cycles, >=1.
- ACC_LEN, 1: number of products summed per output token, >=1. A value of 1 gives a plain product.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous, active-low reset.
- entry_1, in, DATA_W: channel-1 head token, valid while empty_1=0.
- empty_1, in, 1: channel-1 FIFO empty.
- rd_1, out, 1: pop channel 1.
- entry_2, in, DATA_W: channel-2 head token.
- empty_2, in, 1: channel-2 FIFO empty.
- rd_2, out, 1: pop channel 2.
- output_1, out, OUT_W: result token. OUT_W = 2*DATA_W + clog2(ACC_LEN).
- full_o, in, 1: output FIFO full.
- wr, out, 1: push output_1.
- busy, out, 1: high whenever state != IDLE or acc_cnt != 0.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; clock port clk, reset port reset_n.
- Reset values:
  - State = IDLE.
  - rd_1 = rd_2 = wr = 0.
  - output_1 = 0.
  - Accumulator = 0; acc_cnt = 0; busy = 0.
- FSM states: IDLE, MUL, WRITE.
- IDLE:
  - If empty_1=0 and empty_2=0: assert rd_1 and rd_2 together, combinationally, in the same cycle.
  - On that edge, capture entry_1 and entry_2 into the multiplier and move to MUL.
  - Never pop one channel alone.
- MUL:
  - Stay for exactly MUL_LAT cycles.
  - On the last cycle: acc <= acc + product (sign-extended when SIGNED=1, zero-extended otherwise); acc_cnt++.
  - If the new acc_cnt == ACC_LEN: load output_1 <= acc + product, clear acc and acc_cnt, go to WRITE.
  - Otherwise go to IDLE.
- WRITE:
  - wr = !full_o, combinational.
  - Leave for IDLE on the cycle wr=1.
  - output_1 holds stable from WRITE entry until the next write.
- Timing:
  - Latency from rd pulse to wr pulse is MUL_LAT+1 cycles when full_o=0.
  - Throughput is one pair per MUL_LAT+2 cycles; there is no overlapping.
- Boundary conditions:
  - Exactly one channel empty: no pop, stay in IDLE indefinitely.
  - full_o=1 in WRITE: stall; no reads occur while stalled (backpressure propagates).
  - full_o rises in the same cycle WRITE is entered: wr=0, stall.
  - Accumulator overflow is impossible: OUT_W covers ACC_LEN max products.
  - reset_n low mid-operation (any state): immediate return to reset values. Partial accumulation is discarded; popped tokens are lost by design.
  - SIGNED=1 with both operands at minimum value: the product is representable in 2*DATA_W bits; no saturation.

Decomposition:
- Shared package kpn_pkg:
  - state enum (IDLE, MUL, WRITE)
  - clog2 function
  - OUT_W computation helper
- Sub-module kpn_mul_pipe (DATA_W, SIGNED, MUL_LAT):
  - Registered multiplier with a MUL_LAT-deep pipeline.
  - Valid-in/valid-out strobe.
  - Asynchronous active-low reset.
- The FSM, accumulator and handshakes stay in the top level.

Test Plan:
- Defaults; entry_1=0x0010, entry_2=0x0032, both non-empty, full_o=0 -> one rd_1/rd_2 pulse; wr exactly 3 cycles later with output_1=0x00000320.
- SIGNED=1; entry_1=0xFFFE (-2), entry_2=0x0003 -> output_1=0xFFFFFFFA. Also 0x8000*0x8000 -> 0x40000000.
- empty_2 held 1 for 10 cycles while empty_1=0 -> rd_1=rd_2=0 throughout; after empty_2 falls, the pair 0x0020*0x0020 -> 0x00000400.
- full_o=1 from WRITE entry for 5 cycles -> wr=0, output_1 stable, no rd pulses; wr pulses in the cycle full_o falls.
- ACC_LEN=4; pairs (1,2), (3,4), (5,6), (7,8) -> a single wr with output_1=100 (OUT_W=34); no wr after the first three pairs.
- reset_n asserted during MUL after two of four ACC_LEN pairs -> all outputs zero asynchronously; next four pairs of (1,1) -> output_1=4.
